// File: rtl/dmem_pkg.sv
// Shared types and widths for the data-memory arbiter.
//   ADDR_W / DATA_W : default word-address and data widths
//   NUM_REQ         : number of requesters (0 = core LSU, 1 = DMA/debug)
//   state_t         : arbiter FSM states
//   req_t           : latched request payload (we, addr, wdata)
package dmem_pkg;

    localparam int unsigned ADDR_W  = 11;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned NUM_REQ = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

endpackage

// File: rtl/dmem_rr_pick.sv
// Winner selection between the two requesters.
// Macro DMEM_ARB_RR_EN: defined -> round-robin, the last-granted requester
// loses a tie; undefined -> fixed priority, requester 0 wins every tie.
//   valid : request valids, bit N = requester N
//   last  : requester granted most recently (ignored in fixed priority)
//   grant : one-hot winner, all zero when nothing is valid
module dmem_rr_pick
    import dmem_pkg::*;
(
    input  logic [NUM_REQ-1:0] valid,
    input  logic               last,
    output logic [NUM_REQ-1:0] grant
);

`ifdef DMEM_ARB_RR_EN
    // On a tie the requester that did not win last time goes first.
    always_comb begin
        grant = '0;
        if (valid == 2'b11) begin
            grant = last ? 2'b01 : 2'b10;
        end else begin
            grant = valid;
        end
    end
`else
    logic unused_last;
    assign unused_last = last;

    // Requester 0 always has priority.
    always_comb begin
        grant = '0;
        if (valid[0]) begin
            grant = 2'b01;
        end else if (valid[1]) begin
            grant = 2'b10;
        end
    end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-port data_memory with combinational
// read. One transaction is outstanding at a time: IDLE (accept) -> ACCESS
// (memory cycle) -> RESP (hold response until the owner takes it).
// Macro DMEM_ARB_RR_EN selects round-robin instead of fixed priority.
// Ports:
//   i_clk, i_rstn                : clock, async active-low reset
//   i_mN_req_valid/o_mN_req_ready: request handshake (ready is combinational)
//   i_mN_we/i_mN_addr/i_mN_wdata : request payload
//   o_mN_rsp_valid/i_mN_rsp_ready: response handshake
//   o_mN_rsp_rdata               : read data, 0 for write responses
//   o_mem_write/addr/wdata       : data_memory controls
//   i_mem_rdata                  : data_memory read data of o_mem_addr
module dmem_arbiter #(
    parameter int unsigned ADDR_W = dmem_pkg::ADDR_W,
    parameter int unsigned DATA_W = dmem_pkg::DATA_W
) (
    input  logic              i_clk,
    input  logic              i_rstn,

    input  logic              i_m0_req_valid,
    output logic              o_m0_req_ready,
    input  logic              i_m0_we,
    input  logic [ADDR_W-1:0] i_m0_addr,
    input  logic [DATA_W-1:0] i_m0_wdata,
    output logic              o_m0_rsp_valid,
    input  logic              i_m0_rsp_ready,
    output logic [DATA_W-1:0] o_m0_rsp_rdata,

    input  logic              i_m1_req_valid,
    output logic              o_m1_req_ready,
    input  logic              i_m1_we,
    input  logic [ADDR_W-1:0] i_m1_addr,
    input  logic [DATA_W-1:0] i_m1_wdata,
    output logic              o_m1_rsp_valid,
    input  logic              i_m1_rsp_ready,
    output logic [DATA_W-1:0] o_m1_rsp_rdata,

    output logic              o_mem_write,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata
);
    import dmem_pkg::*;

    // Payload register widths follow the package struct.
    localparam int unsigned PA_W = dmem_pkg::ADDR_W;
    localparam int unsigned PD_W = dmem_pkg::DATA_W;

    state_t             state;
    req_t               req_q;
    req_t               win_req;
    logic               owner_q;
    logic               mem_write_q;
    logic [NUM_REQ-1:0] rsp_valid_q;
    logic [PD_W-1:0]    rsp_data_q;
    logic [NUM_REQ-1:0] valid;
    logic [NUM_REQ-1:0] pick;
    logic [NUM_REQ-1:0] grant;
    logic               last_q;
    logic               owner_ready;

    assign valid = {i_m1_req_valid, i_m0_req_valid};

    dmem_rr_pick u_pick (
        .valid (valid),
        .last  (last_q),
        .grant (pick)
    );

    // Grants only exist in IDLE; reset forces ready low with everything else.
    assign grant          = (i_rstn && (state == IDLE)) ? pick : '0;
    assign o_m0_req_ready = grant[0];
    assign o_m1_req_ready = grant[1];

    // Payload of the requester that wins this cycle.
    always_comb begin
        win_req = '0;
        if (pick[1]) begin
            win_req.we    = i_m1_we;
            win_req.addr  = PA_W'(i_m1_addr);
            win_req.wdata = PD_W'(i_m1_wdata);
        end else begin
            win_req.we    = i_m0_we;
            win_req.addr  = PA_W'(i_m0_addr);
            win_req.wdata = PD_W'(i_m0_wdata);
        end
    end

`ifdef DMEM_ARB_RR_EN
    // Last-granted pointer; reset value 1 lets requester 0 win the first tie.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            last_q <= 1'b1;
        end else if (|grant) begin
            last_q <= grant[1];
        end
    end
`else
    assign last_q = 1'b1;
`endif

    assign owner_ready = owner_q ? i_m1_rsp_ready : i_m0_rsp_ready;

    // Transaction FSM with registered memory and response outputs.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state       <= IDLE;
            req_q       <= '0;
            owner_q     <= 1'b0;
            mem_write_q <= 1'b0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|grant) begin
                        req_q       <= win_req;
                        owner_q     <= grant[1];
                        mem_write_q <= win_req.we;
                        state       <= ACCESS;
                    end
                end
                ACCESS: begin
                    // The write strobe covers exactly this one cycle.
                    mem_write_q <= 1'b0;
                    rsp_data_q  <= req_q.we ? '0 : PD_W'(i_mem_rdata);
                    rsp_valid_q <= owner_q ? 2'b10 : 2'b01;
                    state       <= RESP;
                end
                RESP: begin
                    if (owner_ready) begin
                        rsp_valid_q <= '0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    mem_write_q <= 1'b0;
                    rsp_valid_q <= '0;
                    state       <= IDLE;
                end
            endcase
        end
    end

    // Address and data come straight from the request register, so they
    // hold their last values outside ACCESS.
    assign o_mem_write    = mem_write_q;
    assign o_mem_addr     = ADDR_W'(req_q.addr);
    assign o_mem_wdata    = DATA_W'(req_q.wdata);
    assign o_m0_rsp_valid = rsp_valid_q[0];
    assign o_m1_rsp_valid = rsp_valid_q[1];
    assign o_m0_rsp_rdata = DATA_W'(rsp_data_q);
    assign o_m1_rsp_rdata = DATA_W'(rsp_data_q);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: a transaction-level reference model
// (one outstanding request with its acceptance cycle, a reference memory,
// the tie-break rule) is compared with the DUT every cycle, plus directed
// sequences with hand-computed expectations. The bench also plays the
// combinational-read data_memory. Honours DMEM_ARB_RR_EN like the RTL.
`timescale 1ns/1ps
module tb_dmem_arbiter;

    localparam int unsigned AW = 11;
    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          m0_valid = 0, m0_we = 0, m0_rsp_ready = 0;
    logic [AW-1:0] m0_addr = '0;
    logic [DW-1:0] m0_wdata = '0;
    logic          m1_valid = 0, m1_we = 0, m1_rsp_ready = 0;
    logic [AW-1:0] m1_addr = '0;
    logic [DW-1:0] m1_wdata = '0;
    logic          m0_ready, m1_ready, m0_rsp_valid, m1_rsp_valid;
    logic [DW-1:0] m0_rsp_rdata, m1_rsp_rdata;
    logic          mem_write;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .i_clk          (clk),
        .i_rstn         (rstn),
        .i_m0_req_valid (m0_valid),
        .o_m0_req_ready (m0_ready),
        .i_m0_we        (m0_we),
        .i_m0_addr      (m0_addr),
        .i_m0_wdata     (m0_wdata),
        .o_m0_rsp_valid (m0_rsp_valid),
        .i_m0_rsp_ready (m0_rsp_ready),
        .o_m0_rsp_rdata (m0_rsp_rdata),
        .i_m1_req_valid (m1_valid),
        .o_m1_req_ready (m1_ready),
        .i_m1_we        (m1_we),
        .i_m1_addr      (m1_addr),
        .i_m1_wdata     (m1_wdata),
        .o_m1_rsp_valid (m1_rsp_valid),
        .i_m1_rsp_ready (m1_rsp_ready),
        .o_m1_rsp_rdata (m1_rsp_rdata),
        .o_mem_write    (mem_write),
        .o_mem_addr     (mem_addr),
        .o_mem_wdata    (mem_wdata),
        .i_mem_rdata    (mem_rdata)
    );

    // data_memory stand-in: combinational read, synchronous write.
    logic [DW-1:0] mem [0:2047];
    assign mem_rdata = mem[mem_addr];
    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = '0;
        forever begin
            @(posedge clk);
            if (mem_write) mem[mem_addr] <= mem_wdata;
        end
    end

    // Reference model state.
    logic [DW-1:0] ref_mem [0:2047];
    bit            busy;
    int            a_cyc;
    bit            t_owner, t_we;
    logic [AW-1:0] t_addr;
    logic [DW-1:0] t_wdata, t_exp;
    bit            last_g;
    logic [AW-1:0] bus_addr;
    int            cyc;

    // Observations of the DUT for the directed literal checks.
    int            dut_grants[$];
    logic [DW-1:0] got_rdata [2];
    int            t_acc, t_rv, wr_pulses;
    bit            rv_prev;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, act, exp);
        end
    endtask

    function automatic int pick_winner(bit v0, bit v1);
        if (v0 && v1) begin
`ifdef DMEM_ARB_RR_EN
            return last_g ? 0 : 1;
`else
            return 0;
`endif
        end
        return v0 ? 0 : 1;
    endfunction

    task automatic model_reset();
        busy     = 0;
        last_g   = 1;
        bus_addr = '0;
        rv_prev  = 0;
    endtask

    // One clock cycle: drive, compare against the model, advance the model.
    task automatic step(input bit v0, input bit we0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                        input bit v1, input bit we1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                        input bit r0, input bit r1);
        int       w;
        int       ph;
        bit [1:0] er;
        bit       ev0, ev1, emw;
        @(negedge clk);
        m0_valid = v0; m0_we = we0; m0_addr = a0; m0_wdata = d0;
        m1_valid = v1; m1_we = we1; m1_addr = a1; m1_wdata = d1;
        m0_rsp_ready = r0; m1_rsp_ready = r1;
        #1;
        w  = -1;
        er = 2'b00;
        if (!busy && (v0 || v1)) begin
            w = pick_winner(v0, v1);
            er[w] = 1'b1;
        end
        ph  = busy ? (cyc - a_cyc) : -1;
        emw = busy && (ph == 1) && t_we;
        ev0 = busy && (ph >= 2) && !t_owner;
        ev1 = busy && (ph >= 2) && t_owner;
        chk("req_ready0", m0_ready, er[0]);
        chk("req_ready1", m1_ready, er[1]);
        chk("mem_write", mem_write, emw);
        chk("mem_addr", mem_addr, bus_addr);
        if (emw) chk("mem_wdata", mem_wdata, t_wdata);
        chk("rsp_valid0", m0_rsp_valid, ev0);
        chk("rsp_valid1", m1_rsp_valid, ev1);
        if (ev0) chk("rsp_rdata0", m0_rsp_rdata, t_exp);
        if (ev1) chk("rsp_rdata1", m1_rsp_rdata, t_exp);

        if (m0_ready) dut_grants.push_back(0);
        if (m1_ready) dut_grants.push_back(1);
        if (m0_ready || m1_ready) t_acc = cyc;
        if ((m0_rsp_valid || m1_rsp_valid) && !rv_prev) t_rv = cyc;
        rv_prev = m0_rsp_valid || m1_rsp_valid;
        if (m0_rsp_valid && r0) got_rdata[0] = m0_rsp_rdata;
        if (m1_rsp_valid && r1) got_rdata[1] = m1_rsp_rdata;
        if (mem_write) wr_pulses++;

        if (busy && ph == 1 && t_we) ref_mem[t_addr] = t_wdata;
        if (busy && ph >= 2 && (t_owner ? r1 : r0)) begin
            busy = 0;
        end else if (w >= 0) begin
            busy     = 1;
            a_cyc    = cyc;
            t_owner  = (w == 1);
            t_we     = t_owner ? we1 : we0;
            t_addr   = t_owner ? a1 : a0;
            t_wdata  = t_owner ? d1 : d0;
            t_exp    = t_we ? '0 : ref_mem[t_addr];
            last_g   = t_owner;
            bus_addr = t_addr;
        end
        cyc++;
    endtask

    task automatic idle(input int n, input bit r0, input bit r1);
        for (int i = 0; i < n; i++) step(0, 0, '0, '0, 0, 0, '0, '0, r0, r1);
    endtask

    task automatic drive_zero();
        m0_valid = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0; m0_rsp_ready = 0;
        m1_valid = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0; m1_rsp_ready = 0;
    endtask

    // Reset with both requesters asking: nothing may be granted or driven.
    task automatic do_reset();
        @(negedge clk);
        drive_zero();
        m0_valid = 1; m1_valid = 1; m0_rsp_ready = 1; m1_rsp_ready = 1;
        rstn = 0;
        #1;
        chk("rst_ready0", m0_ready, 0);
        chk("rst_ready1", m1_ready, 0);
        chk("rst_mem_write", mem_write, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_rsp_valid", {m1_rsp_valid, m0_rsp_valid}, 0);
        @(negedge clk);
        drive_zero();
        rstn = 1;
        model_reset();
    endtask

    initial begin
        int n_before;
        for (int i = 0; i < 2048; i++) ref_mem[i] = '0;
        cyc = 0;
        wr_pulses = 0;
        model_reset();

        // Write then read back through requester 0.
        do_reset();
        wr_pulses = 0;
        step(1, 1, 11'd0, 32'hA5A5_A5A5, 0, 0, '0, '0, 1, 1);
        idle(2, 1, 1);
        chk("write_pulse_count", wr_pulses, 1);
        got_rdata[0] = 32'hFFFF_FFFF;
        step(1, 0, 11'd0, '0, 0, 0, '0, '0, 1, 1);
        idle(2, 1, 1);
        chk("read_back_rdata", got_rdata[0], 32'hA5A5_A5A5);
        chk("accept_to_rsp_latency", t_rv - t_acc, 2);

        // Cross-requester: m1 writes, m0 reads it back.
        got_rdata[1] = 32'hFFFF_FFFF;
        step(0, 0, '0, '0, 1, 1, 11'd1027, 32'hDEAD_BEEF, 1, 1);
        idle(2, 1, 1);
        chk("write_rsp_rdata_zero", got_rdata[1], 0);
        got_rdata[0] = 32'hFFFF_FFFF;
        step(1, 0, 11'd1027, '0, 0, 0, '0, '0, 1, 1);
        idle(2, 1, 1);
        chk("cross_read_rdata", got_rdata[0], 32'hDEAD_BEEF);

        // Both requesters valid continuously for four transactions.
        do_reset();
        dut_grants.delete();
        for (int i = 0; i < 12; i++) step(1, 0, 11'd100, '0, 1, 0, 11'd100, '0, 1, 1);
        chk("tie_grant_count", dut_grants.size(), 4);
        for (int i = 0; i < 4 && i < dut_grants.size(); i++) begin
`ifdef DMEM_ARB_RR_EN
            chk($sformatf("tie_grant_%0d", i), dut_grants[i], i % 2);
`else
            chk($sformatf("tie_grant_%0d", i), dut_grants[i], 0);
`endif
        end

        // Owner stalls the response for 5 cycles while m1 keeps asking.
        idle(1, 1, 1);
        step(1, 0, 11'd0, '0, 0, 0, '0, '0, 0, 1);
        n_before = dut_grants.size();
        for (int i = 0; i < 6; i++) step(0, 0, '0, '0, 1, 0, 11'd7, '0, 0, 1);
        chk("stall_no_new_ready", dut_grants.size() - n_before, 0);
        chk("stall_rsp_valid", m0_rsp_valid, 1);
        chk("stall_rsp_rdata", m0_rsp_rdata, 32'hA5A5_A5A5);
        step(0, 0, '0, '0, 0, 0, '0, '0, 1, 1);
        idle(3, 1, 1);

        // Reset while a write is in its memory cycle.
        step(1, 1, 11'd5, 32'h1234_5678, 0, 0, '0, '0, 1, 1);
        @(posedge clk);
        #2;
        chk("access_write_high", mem_write, 1);
        drive_zero();
        rstn = 0;
        #1;
        chk("async_write_drop", mem_write, 0);
        chk("async_rsp_valid", {m1_rsp_valid, m0_rsp_valid}, 0);
        @(negedge clk);
        rstn = 1;
        model_reset();
        idle(4, 1, 1);
        chk("dropped_write_mem", mem[5], 0);

        // Randomised traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            logic [AW-1:0] ra0, ra1;
            ra0 = $urandom_range(0, 1) ? AW'($urandom_range(0, 7)) : AW'($urandom_range(2040, 2047));
            ra1 = $urandom_range(0, 1) ? AW'($urandom_range(0, 7)) : AW'($urandom_range(2040, 2047));
            step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, ra0, $urandom,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, ra1, $urandom,
                 $urandom_range(0, 4) < 3, $urandom_range(0, 4) < 3);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
